// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the shared-memory arbiter: FSM states,
// d_size encodings, default limits and the alignment check.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int DEF_TIMEOUT      = 255;
    localparam int DEF_STARVE_LIMIT = 4;

    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        return ((size == SZ_WORD) && (addr_lo != 2'b00)) ||
               ((size == SZ_HALF) && addr_lo[0]);
    endfunction

endpackage

// File: rtl/mem_arbiter_timeout_ctr.sv
// Busy-cycle counter: cleared on each grant, counts BUSY cycles and flags
// the cycle that is the TIMEOUT-th busy cycle of the current access.
module arb_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic reached
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign reached = (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && !reached)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared memory port with timeout and
// misalignment trapping. Define MEM_ARB_STARVE_GUARD_EN to bound fetch starvation.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_RW,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_size,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_RW,
    output logic [DATA_W-1:0] m_wdata,
    output logic [1:0]        m_size,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              err_flag
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              misal_q, misal_d;
    logic              err_q, err_d;

    logic busy, done, abort, misal_done, arb, to_reached, force_fetch;

    assign busy       = (state_q != IDLE);
    assign done       = busy && !misal_q && m_rvalid;
    assign abort      = busy && !misal_q && !m_rvalid && to_reached;
    assign misal_done = (state_q == BUSY_D) && misal_q;
    assign arb        = !reset && ((state_q == IDLE) || done);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    logic [SC_W-1:0] starve_q, starve_d;

    assign force_fetch = if_req && (starve_q == SC_W'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_gnt)
            starve_d = '0;
        else if (d_gnt && (starve_q != SC_W'(STARVE_LIMIT)))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            starve_q <= '0;
        else
            starve_q <= starve_d;
    end
`else
    assign force_fetch = 1'b0;
`endif

    arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (if_gnt || d_gnt),
        .enable  (busy),
        .reached (to_reached)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        misal_d   = misal_q;
        err_d     = err_q;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;

        if (done) begin
            state_d = IDLE;
            if (state_q == BUSY_I) begin
                if_rvalid = 1'b1;
                if_rdata  = rw_q ? '0 : m_rdata;
            end else begin
                d_rvalid = 1'b1;
                d_rdata  = rw_q ? '0 : m_rdata;
            end
        end

        // Timeout and misaligned accesses both complete with zero data and no re-arbitration.
        if (abort || misal_done) begin
            state_d = IDLE;
            err_d   = 1'b1;
            if (state_q == BUSY_I)
                if_rvalid = 1'b1;
            else
                d_rvalid = 1'b1;
        end

        if (arb) begin
            if (d_req && !force_fetch)
                d_gnt = 1'b1;
            else if (if_req)
                if_gnt = 1'b1;
        end

        if (d_gnt) begin
            state_d = BUSY_D;
            addr_d  = d_addr;
            rw_d    = d_RW;
            wdata_d = d_wdata;
            size_d  = d_size;
            misal_d = is_misaligned(d_addr[1:0], d_size);
            if (misal_d)
                err_d = 1'b1;
        end else if (if_gnt) begin
            state_d = BUSY_I;
            addr_d  = if_addr;
            rw_d    = 1'b0;
            wdata_d = '0;
            size_d  = SZ_WORD;
            misal_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            size_q  <= SZ_BYTE;
            misal_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            misal_q <= misal_d;
            err_q   <= err_d;
        end
    end

    assign m_req    = busy && !misal_q;
    assign m_addr   = m_req ? addr_q  : '0;
    assign m_RW     = m_req && rw_q;
    assign m_wdata  = m_req ? wdata_q : '0;
    assign m_size   = m_req ? size_q  : 2'd0;
    assign err_flag = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=8, STARVE_LIMIT=4); the starvation
// pattern expectation follows MEM_ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_RW, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size, m_size;
    logic        m_req, m_RW, m_rvalid, err_flag;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int passes = 0;
    int total  = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_RW(d_RW), .d_wdata(d_wdata),
        .d_size(d_size), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_addr(m_addr), .m_RW(m_RW), .m_wdata(m_wdata),
        .m_size(m_size), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .err_flag(err_flag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic exp_i;
        reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_addr = 0; d_RW = 0;
        d_wdata = 0; d_size = 0; m_rvalid = 0; m_rdata = 0;
        step(); step();
        #1;
        chk("rst_m_req", 32'(m_req), 0);
        chk("rst_err", 32'(err_flag), 0);
        chk("rst_gnt", 32'({if_gnt, d_gnt}), 0);
        reset = 1'b0;

        // Single fetch, memory answers on the third busy cycle
        step(); if_req = 1; if_addr = 32'h100; #1;
        chk("f_if_gnt", 32'(if_gnt), 1);
        chk("f_m_req_c0", 32'(m_req), 0);
        step(); if_req = 0; #1;
        chk("f_m_req_c1", 32'(m_req), 1);
        chk("f_m_addr", m_addr, 32'h100);
        chk("f_m_rw", 32'(m_RW), 0);
        chk("f_rvalid_c1", 32'(if_rvalid), 0);
        step(); #1;
        chk("f_m_req_c2", 32'(m_req), 1);
        step(); m_rvalid = 1; m_rdata = 32'hDEADBEEF; #1;
        chk("f_m_req_c3", 32'(m_req), 1);
        chk("f_rvalid", 32'(if_rvalid), 1);
        chk("f_rdata", if_rdata, 32'hDEADBEEF);
        step(); m_rvalid = 0; m_rdata = 0; #1;
        chk("f_m_req_c4", 32'(m_req), 0);
        chk("f_rvalid_c4", 32'(if_rvalid), 0);
        chk("f_rdata_c4", if_rdata, 0);

        // Simultaneous requests: data first, fetch granted back-to-back
        step(); if_req = 1; if_addr = 32'h400; d_req = 1; d_addr = 32'h200; d_RW = 0; d_size = 2; #1;
        chk("b_d_gnt", 32'(d_gnt), 1);
        chk("b_if_gnt0", 32'(if_gnt), 0);
        step(); d_req = 0; #1;
        chk("b_m_addr_d", m_addr, 32'h200);
        chk("b_if_gnt_busy", 32'(if_gnt), 0);
        step(); m_rvalid = 1; m_rdata = 32'h1234; #1;
        chk("b_d_rvalid", 32'(d_rvalid), 1);
        chk("b_d_rdata", d_rdata, 32'h1234);
        chk("b_if_gnt", 32'(if_gnt), 1);
        step(); m_rvalid = 0; if_req = 0; #1;
        chk("b_m_req", 32'(m_req), 1);
        chk("b_m_addr_i", m_addr, 32'h400);
        step(); m_rvalid = 1; m_rdata = 32'hCAFE; #1;
        chk("b_if_rvalid", 32'(if_rvalid), 1);
        chk("b_if_rdata", if_rdata, 32'hCAFE);
        step(); m_rvalid = 0; #1;
        chk("b_m_req_end", 32'(m_req), 0);

        // Byte write
        step(); d_req = 1; d_RW = 1; d_addr = 32'h300; d_wdata = 32'h55; d_size = 0; #1;
        chk("w_d_gnt", 32'(d_gnt), 1);
        step(); d_req = 0; #1;
        chk("w_m_rw", 32'(m_RW), 1);
        chk("w_m_wdata", m_wdata, 32'h55);
        chk("w_m_size", 32'(m_size), 0);
        step(); m_rvalid = 1; m_rdata = 32'hFFFFFFFF; #1;
        chk("w_d_rvalid", 32'(d_rvalid), 1);
        chk("w_d_rdata", d_rdata, 0);
        step(); m_rvalid = 0; #1;
        chk("w_err", 32'(err_flag), 0);

        // Aligned half-word at 0x302 must reach memory
        step(); d_req = 1; d_RW = 0; d_addr = 32'h302; d_size = 1; #1;
        chk("h_d_gnt", 32'(d_gnt), 1);
        step(); d_req = 0; #1;
        chk("h_m_req", 32'(m_req), 1);
        chk("h_m_size", 32'(m_size), 1);
        step(); m_rvalid = 1; m_rdata = 32'hBEEF; #1;
        chk("h_d_rdata", d_rdata, 32'hBEEF);
        step(); m_rvalid = 0; #1;
        chk("h_err", 32'(err_flag), 0);

        // m_rvalid while idle is ignored
        m_rvalid = 1; #1;
        chk("idle_rvalid", 32'({if_rvalid, d_rvalid}), 0);
        m_rvalid = 0;

        // Misaligned word read
        step(); d_req = 1; d_addr = 32'h202; d_size = 2; m_rdata = 32'h7777; #1;
        chk("m_d_gnt", 32'(d_gnt), 1);
        step(); d_req = 0; #1;
        chk("m_m_req", 32'(m_req), 0);
        chk("m_d_rvalid", 32'(d_rvalid), 1);
        chk("m_d_rdata", d_rdata, 0);
        chk("m_err", 32'(err_flag), 1);
        step(); #1;
        chk("m_m_req2", 32'(m_req), 0);
        chk("m_d_rvalid2", 32'(d_rvalid), 0);
        chk("m_err_sticky", 32'(err_flag), 1);

        // Timeout after 8 busy cycles
        reset = 1; step(); reset = 0; #1;
        chk("t_err_clr", 32'(err_flag), 0);
        if_req = 1; if_addr = 32'h500; m_rdata = 32'hBAD0BAD0; #1;
        chk("t_if_gnt", 32'(if_gnt), 1);
        step(); if_req = 0; #1;
        for (int k = 1; k < 8; k++) begin
            chk($sformatf("t_m_req_%0d", k), 32'(m_req), 1);
            chk($sformatf("t_rvalid_%0d", k), 32'(if_rvalid), 0);
            step(); #1;
        end
        chk("t_abort_rvalid", 32'(if_rvalid), 1);
        chk("t_abort_rdata", if_rdata, 0);
        step(); #1;
        chk("t_m_req_drop", 32'(m_req), 0);
        chk("t_err", 32'(err_flag), 1);
        step(); step(); #1;
        chk("t_err_hold", 32'(err_flag), 1);

        // Reset mid-access drops it silently
        reset = 1; step(); reset = 0; #1;
        if_req = 1; if_addr = 32'h600; #1;
        chk("r_if_gnt", 32'(if_gnt), 1);
        step(); if_req = 0; #1;
        chk("r_m_req", 32'(m_req), 1);
        reset = 1;
        step(); if_req = 1; m_rvalid = 1; #1;
        chk("r_m_req_clr", 32'(m_req), 0);
        chk("r_m_addr_clr", m_addr, 0);
        chk("r_rvalid", 32'({if_rvalid, d_rvalid}), 0);
        chk("r_gnt", 32'({if_gnt, d_gnt}), 0);
        chk("r_err", 32'(err_flag), 0);
        step(); reset = 0; if_req = 0; m_rvalid = 0; #1;
        chk("r_m_req_after", 32'(m_req), 0);

        // Both ports held high, memory completes every busy cycle
        step(); d_req = 1; d_RW = 0; d_addr = 32'h700; d_size = 2; if_req = 1; if_addr = 32'h800;
        m_rvalid = 1; m_rdata = 32'h1; #1;
        for (int k = 0; k < 15; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_i = ((k % 5) == 4);
`else
            exp_i = 1'b0;
`endif
            chk($sformatf("s_d_gnt_%0d", k), 32'(d_gnt), 32'(!exp_i));
            chk($sformatf("s_if_gnt_%0d", k), 32'(if_gnt), 32'(exp_i));
            step(); #1;
        end
        d_req = 0; if_req = 0; #1;
        step(); m_rvalid = 0; #1;
        chk("s_idle", 32'(m_req), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
